// File: rtl/pi1_to_wb4_pipe.sv
// PI1 to Wishbone B4 pipelined bridge: one transaction at a time, RW runs as a
// locked read-then-write, each bus phase is guarded by a timeout counter.
module pi1_to_wb4_pipe #(
  parameter int unsigned ARCHBITSZ = 32,
  parameter int unsigned TIMEOUT   = 256,
  localparam int unsigned SELBITSZ  = ARCHBITSZ / 8,
  localparam int unsigned LSBBITSZ  = $clog2(SELBITSZ),
  localparam int unsigned ADDRBITSZ = ARCHBITSZ - LSBBITSZ
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           pi1_op_i,
  input  logic [ADDRBITSZ-1:0] pi1_addr_i,
  input  logic [ARCHBITSZ-1:0] pi1_data_i,
  input  logic [SELBITSZ-1:0]  pi1_sel_i,
  output logic [ARCHBITSZ-1:0] pi1_data_o,
  output logic                 pi1_rdy_o,
  output logic                 wb4_cyc_o,
  output logic                 wb4_stb_o,
  output logic                 wb4_we_o,
  output logic [ARCHBITSZ-1:0] wb4_addr_o,
  output logic [ARCHBITSZ-1:0] wb4_data_o,
  output logic [SELBITSZ-1:0]  wb4_sel_o,
  input  logic                 wb4_stall_i,
  input  logic                 wb4_ack_i,
  input  logic                 wb4_err_i,
  input  logic [ARCHBITSZ-1:0] wb4_data_i,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RWWR} state_e;
  typedef enum logic [1:0] {OP_NOOP, OP_WR, OP_RD, OP_RW} op_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic                 rw_q, rw_d;
  logic                 err_q, err_d;
  logic [ARCHBITSZ-1:0] rdata_q, rdata_d;
  logic [ARCHBITSZ-1:0] addr_q, addr_d;
  logic [ARCHBITSZ-1:0] wdata_q, wdata_d;
  logic [SELBITSZ-1:0]  sel_q, sel_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [LSBBITSZ-1:0]  lsb;

  always_comb begin
    lsb = '0;
    for (int unsigned i = SELBITSZ; i > 0; i--) begin
      if (pi1_sel_i[i-1]) lsb = LSBBITSZ'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    rw_d    = rw_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (pi1_op_i != OP_NOOP) begin
          addr_d  = {pi1_addr_i, lsb};
          wdata_d = pi1_data_i;
          sel_d   = pi1_sel_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = (pi1_op_i == OP_WR);
          rw_d    = (pi1_op_i == OP_RW);
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      default: begin
        cnt_d = cnt_q + 16'd1;
        if (wb4_err_i) begin
          if (!we_q) rdata_d = '0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          rw_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (wb4_ack_i) begin
          // RW read completion keeps the cycle locked and launches the write.
          if (rw_q && !we_q) begin
            rdata_d = wb4_data_i;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            cnt_d   = '0;
            state_d = RWWR;
          end else begin
            if (!we_q) rdata_d = wb4_data_i;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            rw_d    = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          rw_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q != WAIT && !wb4_stall_i) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pi1_rdy_o  = (state_q == IDLE);
  assign pi1_data_o = rdata_q;
  assign wb4_cyc_o  = cyc_q;
  assign wb4_stb_o  = stb_q;
  assign wb4_we_o   = we_q;
  assign wb4_addr_o = addr_q;
  assign wb4_data_o = wdata_q;
  assign wb4_sel_o  = sel_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_pi1_to_wb4_pipe.sv
// Bench for pi1_to_wb4_pipe: reactive slave plus an arithmetic model of
// latency, result data and error pulses per transaction.
module tb_pi1_to_wb4_pipe;

  localparam int TO = 8;
  localparam logic [1:0] OP_NOOP = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2, OP_RW = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] pi1_data_o;
  logic        pi1_rdy_o;
  logic        wb4_cyc_o, wb4_stb_o, wb4_we_o;
  logic [31:0] wb4_addr_o, wb4_data_o;
  logic [3:0]  wb4_sel_o;
  logic        stall, ack, err;
  logic [31:0] sdata;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdata;

  pi1_to_wb4_pipe #(.ARCHBITSZ(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .pi1_op_i(op), .pi1_addr_i(addr), .pi1_data_i(wdata), .pi1_sel_i(sel),
    .pi1_data_o(pi1_data_o), .pi1_rdy_o(pi1_rdy_o),
    .wb4_cyc_o(wb4_cyc_o), .wb4_stb_o(wb4_stb_o), .wb4_we_o(wb4_we_o),
    .wb4_addr_o(wb4_addr_o), .wb4_data_o(wb4_data_o), .wb4_sel_o(wb4_sel_o),
    .wb4_stall_i(stall), .wb4_ack_i(ack), .wb4_err_i(err), .wb4_data_i(sdata),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] o, input logic [29:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input int s1, input int d1, input int e1,
                         input int s2, input int d2, input int e2,
                         input logic [31:0] r1, input logic [31:0] r2, input string tag);
    int explat, l1, l2, left, cd, ph, lat, cyccnt, e;
    logic [31:0] expd, expaddr, acc_addr, acc_wdata;
    logic [3:0]  iso, acc_sel;
    logic        experr, acc, gap;
    int          stbcnt[3];
    logic        wephase[3];

    // expected results from phase lengths: stall + accept cycle + ack delay
    l1 = s1 + 1 + d1;
    l2 = s2 + 1 + d2;
    expd = mdata;
    experr = 1'b0;
    if (l1 > TO) begin
      explat = TO + 1; expd = '1; experr = 1'b1;
    end else if (e1 != 0) begin
      explat = l1 + 1; experr = 1'b1;
      if (o != OP_WR) expd = '0;
    end else if (o == OP_WR) begin
      explat = l1 + 1;
    end else begin
      expd = r1; explat = l1 + 1;
      if (o == OP_RW) begin
        if (l2 > TO) begin
          explat = l1 + TO + 1; expd = '1; experr = 1'b1;
        end else begin
          explat = l1 + l2 + 1;
          if (e2 != 0) experr = 1'b1;
        end
      end
    end
    iso = s & (-s);
    expaddr = {a, 2'b00} + 32'($clog2(iso));

    left = s1; acc = 1'b0; cd = 0; ph = 0; lat = -1; cyccnt = 0; gap = 1'b0;
    acc_addr = '0; acc_wdata = '0; acc_sel = '0;
    for (int i = 0; i < 3; i++) begin stbcnt[i] = 0; wephase[i] = 1'b0; end

    chk({tag, " rdy_before"}, pi1_rdy_o, 1);
    op = o; addr = a; sel = s; wdata = wd;
    for (int t = 1; t <= 40 && lat < 0; t++) begin
      @(negedge clk);
      op = OP_NOOP; addr = 30'($urandom); wdata = $urandom; sel = 4'($urandom);
      stall = 1'b0; ack = 1'b0; err = 1'b0; sdata = $urandom;
      if (pi1_rdy_o) lat = t;
      else begin
        if (wb4_cyc_o) cyccnt++; else gap = 1'b1;
        if (wb4_stb_o && ph < 3) stbcnt[ph]++;
        if (wb4_stb_o && !acc) begin
          if (left > 0) begin
            stall = 1'b1; left--;
          end else begin
            acc = 1'b1;
            cd = (ph == 0) ? d1 : d2;
            if (ph < 3) wephase[ph] = wb4_we_o;
            if (ph == 0) begin
              acc_addr = wb4_addr_o; acc_wdata = wb4_data_o; acc_sel = wb4_sel_o;
            end
          end
        end
        if (acc) begin
          if (cd == 0) begin
            e = (ph == 0) ? e1 : e2;
            err = (e != 0);
            ack = (e != 1);
            sdata = (ph == 0) ? r1 : r2;
            acc = 1'b0; ph++; left = s2;
          end else cd--;
        end
      end
    end

    chk({tag, " latency"}, lat, explat);
    chk({tag, " stb_cycles"}, stbcnt[0], s1 + 1);
    chk({tag, " we"}, wephase[0], (o == OP_WR));
    chk({tag, " addr"}, acc_addr, expaddr);
    chk({tag, " wdata"}, acc_wdata, wd);
    chk({tag, " sel"}, acc_sel, s);
    if (o == OP_RW && l1 <= TO && e1 == 0) begin
      chk({tag, " wr_stb_cycles"}, stbcnt[1], s2 + 1);
      chk({tag, " wr_we"}, wephase[1], 1);
    end
    chk({tag, " cyc_gap"}, gap, 0);
    chk({tag, " cyc_cycles"}, cyccnt, explat - 1);
    chk({tag, " addr_hold"}, wb4_addr_o, expaddr);
    chk({tag, " data_o"}, pi1_data_o, expd);
    chk({tag, " err_o"}, err_o, experr);
    @(negedge clk);
    stall = 1'b0; ack = 1'b0; err = 1'b0;
    chk({tag, " err_o_after"}, err_o, 0);
    chk({tag, " cyc_after"}, wb4_cyc_o, 0);
    chk({tag, " stb_after"}, wb4_stb_o, 0);
    chk({tag, " we_after"}, wb4_we_o, 0);
    mdata = expd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o, s1, d1, e1, s2, d2, e2;
    rst = 1'b1; op = OP_NOOP; addr = '0; wdata = '0; sel = '0;
    stall = 1'b0; ack = 1'b0; err = 1'b0; sdata = '0;
    mdata = '0;
    repeat (3) @(negedge clk);
    chk("rst cyc", wb4_cyc_o, 0);
    chk("rst stb", wb4_stb_o, 0);
    chk("rst we", wb4_we_o, 0);
    chk("rst err_o", err_o, 0);
    chk("rst data_o", pi1_data_o, 0);
    chk("rst addr", wb4_addr_o, 0);
    chk("rst wdata", wb4_data_o, 0);
    chk("rst sel", wb4_sel_o, 0);
    chk("rst rdy", pi1_rdy_o, 1);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr = 30'($urandom); wdata = $urandom; sel = 4'($urandom);
      chk("noop cyc", wb4_cyc_o, 0);
      chk("noop stb", wb4_stb_o, 0);
      chk("noop rdy", pi1_rdy_o, 1);
    end
    @(negedge clk);

    run_txn(OP_RD, 30'h10, 4'hF, 32'h5555AAAA, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0, "rd_basic");
    run_txn(OP_WR, 30'h123, 4'h4, 32'h00AB0000, 5, 1, 0, 0, 0, 0, 32'h0, 0, "wr_stall");
    run_txn(OP_RW, 30'h2A, 4'h3, 32'hFEED0001, 0, 1, 0, 0, 1, 0, 32'h1234, 0, "rw_swap");
    run_txn(OP_RD, 30'h77, 4'h8, 32'h0, 0, 1, 2, 0, 0, 0, 32'h99999999, 0, "rd_err_ack");
    run_txn(OP_RD, 30'h5, 4'h2, 32'h0, 0, 99, 0, 0, 0, 0, 32'h0, 0, "rd_timeout");
    run_txn(OP_RD, 30'h6, 4'h1, 32'h0, 0, 0, 0, 0, 0, 0, 32'hA5A50F0F, 0, "rd_same_cycle_ack");
    run_txn(OP_RW, 30'h9, 4'h0, 32'h11112222, 1, 0, 0, 0, 99, 0, 32'h3333, 0, "rw_wr_timeout");

    // reset during WAIT, then a late ack
    op = OP_RD; addr = 30'h44; sel = 4'hF; wdata = '0;
    @(negedge clk);
    op = OP_NOOP;
    @(negedge clk);
    chk("rstmid cyc_wait", wb4_cyc_o, 1);
    chk("rstmid stb_wait", wb4_stb_o, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid cyc", wb4_cyc_o, 0);
    chk("rstmid data_o", pi1_data_o, 0);
    chk("rstmid rdy", pi1_rdy_o, 1);
    ack = 1'b1; sdata = 32'hCAFEF00D;
    @(negedge clk);
    ack = 1'b0;
    chk("rstmid late_ack data_o", pi1_data_o, 0);
    chk("rstmid late_ack cyc", wb4_cyc_o, 0);
    chk("rstmid late_ack err_o", err_o, 0);
    mdata = '0;

    for (int n = 0; n < 40; n++) begin
      o  = $urandom_range(1, 3);
      s1 = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
      s2 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
      e1 = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      e2 = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      if ($urandom_range(0, 9) == 0) d1 = 9;
      if ($urandom_range(0, 9) == 0) d2 = 9;
      run_txn(2'(o), 30'($urandom), 4'($urandom), $urandom, s1, d1, e1, s2, d2, e2,
              $urandom, $urandom, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
